// File: rtl/grng_pkg.sv
`default_nettype none
// ============================================================================
//  grng_pkg
//  Shared Q-format constants, scheduler state encoding and counter width.
//  Revision: 1.0
// ============================================================================
package grng_pkg;

    localparam int INT_BITS = 4;                   // sign + 3 integer bits
    localparam int IN_FRAC  = 28;
    localparam int OUT_FRAC = 14;
    localparam int DROP     = IN_FRAC - OUT_FRAC;
    localparam int CNT_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/grng_trunc_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  rr_arbiter
//  Round-robin one-hot arbiter; pointer moves past the winner on each grant.
//  Revision: 1.0
// ============================================================================
module rr_arbiter #(
    parameter int LANES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LANES-1:0]           req,
    output logic [LANES-1:0]           gnt,
    output logic [$clog2(LANES)-1:0]   gnt_idx,
    output logic                       gnt_any
);

    localparam int c_PTR_W = $clog2(LANES);

    logic [c_PTR_W-1:0] r_ptr;
    int                 w_pos;

    // Search starts at the pointer and wraps; first requester wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        w_pos   = 0;
        for (int i = 0; i < LANES; i++) begin
            w_pos = int'(r_ptr) + i;
            if (w_pos >= LANES) begin
                w_pos = w_pos - LANES;
            end
            if (!gnt_any && req[w_pos]) begin
                gnt_any     = 1'b1;
                gnt[w_pos]  = 1'b1;
                gnt_idx     = c_PTR_W'(w_pos);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (gnt_any) begin
            if (gnt_idx == c_PTR_W'(LANES - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= gnt_idx + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/grng_trunc_scheduler.sv
`default_nettype none
// ============================================================================
//  grng_trunc_scheduler
//  Shares one Q3.28 -> Q3.14 truncation/output register among GRNG lanes.
//  Revision: 1.0
// ============================================================================
module grng_trunc_scheduler
    import grng_pkg::*;
#(
    parameter int LANES = 4,
    parameter int IN_W  = INT_BITS + IN_FRAC,
    parameter int OUT_W = INT_BITS + OUT_FRAC
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [LANES-1:0]           lane_mask,
    input  logic [LANES*IN_W-1:0]      lane_data,
    input  logic [LANES-1:0]           lane_valid,
    output logic [LANES-1:0]           lane_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic [$clog2(LANES)-1:0]   out_lane,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       idle,
    output logic [CNT_W-1:0]           sample_count
);

    localparam int c_DROP  = IN_W - OUT_W;
    localparam int c_PTR_W = $clog2(LANES);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_can_accept;
    logic                 w_grant_ok;
    logic [LANES-1:0]     w_req;
    logic [LANES-1:0]     w_gnt;
    logic [c_PTR_W-1:0]   w_gnt_idx;
    logic                 w_gnt_any;
    logic [OUT_W-1:0]     w_samp [LANES];
    logic [LANES-1:0]     w_unused_drop;

    assign w_can_accept = !out_valid || out_ready;
    assign w_grant_ok   = (r_state == RUN) && enable && w_can_accept;
    assign w_req        = lane_valid & lane_mask & {LANES{w_grant_ok}};
    assign lane_ready   = w_gnt;
    assign idle         = (r_state == IDLE) && !out_valid;

    // Truncation is a plain slice: floor toward -inf, integer part kept.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_samp[g]        = lane_data[g*IN_W + c_DROP +: OUT_W];
        assign w_unused_drop[g] = ^lane_data[g*IN_W +: c_DROP];
    end

    rr_arbiter #(
        .LANES   (LANES)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (w_req),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .gnt_any (w_gnt_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (enable) w_state_nxt = RUN;
            RUN:     if (!enable) w_state_nxt = DRAIN;
            DRAIN: begin
                if (enable) begin
                    w_state_nxt = RUN;
                end else if (!out_valid || out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A grant reloads the register even in the cycle it hands off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_lane     <= '0;
            sample_count <= '0;
        end else begin
            if (out_valid && out_ready) begin
                sample_count <= sample_count + 1'b1;
            end
            if (w_gnt_any) begin
                out_valid <= 1'b1;
                out_data  <= w_samp[w_gnt_idx];
                out_lane  <= w_gnt_idx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_grng_trunc_scheduler.sv
`default_nettype none
// ============================================================================
//  tb_grng_trunc_scheduler
//  Directed bench with a scoreboard of lane handshakes vs. output handshakes.
//  Revision: 1.0
// ============================================================================
module tb_grng_trunc_scheduler;

    localparam int c_LANES = 4;
    localparam int c_IN_W  = 32;
    localparam int c_OUT_W = 18;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    enable;
    logic [c_LANES-1:0]      lane_mask;
    logic [c_LANES*c_IN_W-1:0] lane_data;
    logic [c_LANES-1:0]      lane_valid;
    logic [c_LANES-1:0]      lane_ready;
    logic [c_OUT_W-1:0]      out_data;
    logic [1:0]              out_lane;
    logic                    out_valid;
    logic                    out_ready;
    logic                    idle;
    logic [15:0]             sample_count;

    int tests    = 0;
    int fails    = 0;
    int push_cnt = 0;
    logic [19:0] sb [$];

    grng_trunc_scheduler #(
        .LANES        (c_LANES),
        .IN_W         (c_IN_W),
        .OUT_W        (c_OUT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .lane_mask    (lane_mask),
        .lane_data    (lane_data),
        .lane_valid   (lane_valid),
        .lane_ready   (lane_ready),
        .out_data     (out_data),
        .out_lane     (out_lane),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .idle         (idle),
        .sample_count (sample_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] trunc_model(input logic [31:0] v);
        logic signed [31:0] s;
        s = $signed(v) >>> 14;
        return s[17:0];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: output handshake pops first (it holds an earlier grant).
    always @(negedge clk) begin
        logic [19:0] e;
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("sb_data", 32'(out_data), 32'(e[17:0]));
                    check("sb_lane", 32'(out_lane), 32'(e[19:18]));
                end
            end
            check("ready_onehot0", 32'($onehot0(lane_ready)), 32'd1);
            for (int i = 0; i < c_LANES; i++) begin
                if (lane_valid[i] && lane_ready[i]) begin
                    sb.push_back({2'(i), trunc_model(lane_data[i*c_IN_W +: c_IN_W])});
                    push_cnt++;
                end
            end
        end
    end

    initial begin
        logic [1:0] prev;
        int budget;

        // Reset state
        rst        = 1'b1;
        enable     = 1'b0;
        lane_mask  = 4'hF;
        lane_data  = '0;
        lane_valid = '0;
        out_ready  = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_lane", 32'(out_lane), 32'd0);
        check("rst_count", 32'(sample_count), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_lane_ready", 32'(lane_ready), 32'd0);
        cyc();
        cyc();
        rst    = 1'b0;
        enable = 1'b1;
        cyc();

        // Single lane 0, negative sample
        lane_data[31:0] = 32'hFAAA_AAAB;
        lane_valid      = 4'b0001;
        out_ready       = 1'b1;
        #1;
        check("t1_lane_ready", 32'(lane_ready), 32'h1);
        cyc();
        lane_valid = '0;
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_out_data", 32'(out_data), 32'h3EAAA);
        check("t1_out_lane", 32'(out_lane), 32'd0);
        cyc();
        check("t1_count", 32'(sample_count), 32'd1);
        check("t1_out_valid_clr", 32'(out_valid), 32'd0);

        // Lane 2 with downstream stalled
        lane_data[95:64] = 32'h0555_5555;
        lane_valid       = 4'b0100;
        out_ready        = 1'b0;
        cyc();
        lane_valid = 4'b0010;
        check("t2_out_data", 32'(out_data), 32'h01555);
        check("t2_out_lane", 32'(out_lane), 32'd2);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t2_ready_blocked", 32'(lane_ready), 32'd0);
            cyc();
            check("t2_hold_data", 32'(out_data), 32'h01555);
            check("t2_hold_valid", 32'(out_valid), 32'd1);
        end
        lane_valid = '0;
        out_ready  = 1'b1;
        cyc();
        check("t2_out_valid_clr", 32'(out_valid), 32'd0);
        check("t2_count", 32'(sample_count), 32'd2);

        // All lanes streaming; pointer sits at 3 after lanes 0 then 2
        lane_data  = {32'h7FFF_C000, 32'h8000_0000, 32'h0001_3FFF, 32'hFFFF_FFFF};
        lane_valid = 4'hF;
        prev       = 2'd3;
        for (int k = 0; k < 8; k++) begin
            cyc();
            check("t3_valid", 32'(out_valid), 32'd1);
            check("t3_rr_lane", 32'(out_lane), 32'(prev));
            prev = prev + 2'd1;
        end
        budget = 0;
        while (push_cnt < 70000 && budget < 80000) begin
            cyc();
            budget++;
        end
        lane_valid = '0;
        check("t3_pushes", 32'(push_cnt), 32'd70000);
        cyc();
        cyc();
        check("t3_count_wrap", 32'(sample_count), 32'd4464);
        check("t3_drained", 32'(out_valid), 32'd0);
        check("t3_sb_empty", 32'(sb.size()), 32'd0);

        // Mask out lanes 0 and 2
        lane_mask  = 4'b1010;
        lane_valid = 4'hF;
        prev       = 2'd0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            check("t4_valid", 32'(out_valid), 32'd1);
            check("t4_odd_lane", 32'(out_lane[0]), 32'd1);
            if (k > 0) begin
                check("t4_alternate", 32'(out_lane), 32'(prev ^ 2'b10));
            end
            prev = out_lane;
            #1;
            check("t4_masked_ready", 32'(lane_ready & 4'b0101), 32'd0);
        end
        lane_valid = '0;
        lane_mask  = 4'hF;
        cyc();
        cyc();

        // Drain with a pending stalled sample
        lane_valid = 4'b0001;
        out_ready  = 1'b0;
        cyc();
        lane_valid = 4'hF;
        enable     = 1'b0;
        #1;
        check("t5_no_grant_run", 32'(lane_ready), 32'd0);
        cyc();
        for (int k = 0; k < 3; k++) begin
            check("t5_idle_low", 32'(idle), 32'd0);
            check("t5_pending", 32'(out_valid), 32'd1);
            #1;
            check("t5_no_grant_drain", 32'(lane_ready), 32'd0);
            cyc();
        end
        lane_valid = '0;
        out_ready  = 1'b1;
        cyc();
        check("t5_idle", 32'(idle), 32'd1);
        check("t5_out_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset with a pending sample
        enable     = 1'b1;
        lane_valid = 4'b0100;
        out_ready  = 1'b0;
        cyc();
        cyc();
        lane_valid = '0;
        check("t6_pending", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_data", 32'(out_data), 32'd0);
        check("t6_rst_count", 32'(sample_count), 32'd0);
        check("t6_rst_ready", 32'(lane_ready), 32'd0);
        cyc();
        rst        = 1'b0;
        lane_valid = 4'hF;
        out_ready  = 1'b1;
        cyc();
        #1;
        check("t6_first_grant", 32'(lane_ready), 32'h1);
        cyc();
        lane_valid = '0;
        check("t6_out_lane", 32'(out_lane), 32'd0);
        cyc();
        cyc();
        check("t6_sb_empty", 32'(sb.size()), 32'd0);
        check("t6_count", 32'(sample_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/grng_trunc_scheduler.md
# grng_trunc_scheduler

Round-robin scheduler that shares one Q3.28→Q3.14 truncation/output stage among several Gaussian sample lanes in the GRNG core. Each lane offers 32-bit Q3.28 samples under valid/ready. The block grants one lane per cycle, truncates the granted sample to 18-bit Q3.14 and presents it on a single valid/ready output tagged with its lane index. Enable/drain control and a delivered-sample counter let the top level stop the generator cleanly.

## Interface
- LANES, 4, number of requesting lanes (2..8)
- IN_W, 32, input sample width (Q3.28)
- OUT_W, 18, output sample width (Q3.14); IN_W-OUT_W = 14 fraction bits dropped
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  1 = grant new samples; 0 = stop granting and drain
- lane_mask  in  LANES  1 = lane eligible for grant
- lane_data  in  LANES*IN_W  lane i sample at [i*IN_W +: IN_W], signed Q3.28
- lane_valid  in  LANES  lane i offers a sample
- lane_ready  out  LANES  one-hot grant; transfer when lane_valid[i] & lane_ready[i]
- out_data  out  OUT_W  signed Q3.14 sample
- out_lane  out  $clog2(LANES)  source lane of out_data
- out_valid  out  1  output holds a sample
- out_ready  in  1  downstream accepts
- idle  out  1  state IDLE and output empty
- sample_count  out  16  output handshakes since reset, wraps 0xFFFF→0

## Operation
- Truncation: out_data = sample[IN_W-1 : IN_W-OUT_W], i.e. arithmetic shift right by 14, floor toward −∞, no rounding or saturation (Q3 integer part preserved exactly).
- Slot free ("can_accept") = !out_valid | out_ready.
- Eligible lanes: lane_valid & lane_mask. Grant only in RUN and when can_accept.
- Round-robin: search starts at pointer ptr, ascending with wrap; first eligible lane wins. After grant to lane k, ptr ← (k+1) mod LANES. ptr unchanged when nothing is granted.
- lane_ready is combinational from lane_valid, lane_mask, state, out_valid, out_ready; at most one bit set; all zero when no eligible lane.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE → RUN when enable=1.
  - RUN → DRAIN when enable=0 (no grant in that cycle).
  - DRAIN: no grants; → IDLE when out_valid=0 or the pending sample handshakes this cycle; → RUN if enable returns to 1 first.
- Output register: loaded on grant with truncated data and lane index. Held stable while out_valid & !out_ready. Cleared to out_valid=0 on handshake without a new grant.
- Simultaneous output handshake and new grant: the register reloads in the same cycle, so back-to-back throughput is one sample per cycle.
- sample_count increments on every out_valid & out_ready.
- Masking a lane mid-stream takes effect on the next grant decision. An already registered sample from that lane is still delivered.

## Timing
- Reset values: out_valid=0, out_data=0, out_lane=0, sample_count=0, ptr=0, state=IDLE, idle=1, lane_ready=0.
- Reset mid-operation discards the pending output sample immediately (asynchronous).
- Latency: lane handshake in cycle N → out_valid=1 with that sample at the edge ending cycle N (visible in cycle N+1).
- enable falling in cycle N: no grant from cycle N onward; idle=1 one cycle after the last output handshake.
- enable rising in IDLE: first grant possible in the cycle after the FSM reaches RUN.
- No combinational path from out_ready to out_valid or out_data. The out_ready→lane_ready path is permitted.

## Structure
- Shared package grng_pkg holds the Q-format constants (IN_FRAC=28, OUT_FRAC=14, DROP=14), the state enum {IDLE, RUN, DRAIN}, and the sample_count width.
- One natural sub-module, rr_arbiter (LANES-wide request/grant with pointer update). The truncation is a slice inside the top module, not a separate instance.

## Test plan
- Single lane 0, value 0xFAAA_AAAB, out_ready=1 → next cycle out_valid=1, out_data=0x3EAAA, out_lane=0, sample_count=1.
- Lane 2 sends 0x0555_5555 while out_ready=0 for 3 cycles → out_data=0x01555 held stable; lane_ready=0 for all lanes until out_ready=1; exactly one sample delivered.
- All 4 lanes valid continuously, out_ready=1 → out_lane sequence 0,1,2,3,0,… at one sample per cycle; after 70000 samples sample_count = 70000 mod 65536 = 4464.
- lane_mask=4'b1010 with all lanes valid → only lanes 1,3 granted, alternating; lane_ready[0] and lane_ready[2] never set.
- enable dropped with a pending output and out_ready=0 → state DRAIN, no new grants; after out_ready=1 handshake, idle=1 next cycle.
- rst asserted asynchronously while out_valid=1 → out_valid, out_data, sample_count and ptr all 0 immediately; after release, first grant goes to lane 0.
